// File: rtl/bp_cce_dir_entry_writer.sv
// bp_cce_dir_entry_writer: read-modify-write of one directory entry (tag + coherence state) in a packed RAM row
module bp_cce_dir_entry_writer #(
    parameter int num_way_groups_p   = 64,
    parameter int num_lce_p          = 4,
    parameter int lce_assoc_p        = 8,
    parameter int tag_sets_per_row_p = 2,
    parameter int rows_per_wg_p      = 2,
    parameter int tag_width_p        = 10,
    parameter int coh_bits_p         = 3,
    localparam int wg_w         = $clog2(num_way_groups_p),
    localparam int lce_w        = $clog2(num_lce_p),
    localparam int way_w        = $clog2(lce_assoc_p),
    localparam int entry_w      = tag_width_p + coh_bits_p,
    localparam int row_width_lp = tag_sets_per_row_p * lce_assoc_p * entry_w,
    localparam int addr_w       = $clog2(num_way_groups_p * rows_per_wg_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    v_i,
    output logic                    ready_o,
    input  logic [wg_w-1:0]         wg_i,
    input  logic [lce_w-1:0]        lce_i,
    input  logic [way_w-1:0]        way_i,
    input  logic [tag_width_p-1:0]  tag_i,
    input  logic [coh_bits_p-1:0]   state_i,
    input  logic                    state_only_i,
    output logic                    ram_v_o,
    output logic                    ram_w_o,
    output logic [addr_w-1:0]       ram_addr_o,
    output logic [row_width_lp-1:0] ram_data_o,
    input  logic [row_width_lp-1:0] ram_data_i,
    output logic                    done_o
);
    typedef enum logic [1:0] {e_ready, e_read, e_merge, e_write} state_e;

    state_e                  state_q, state_d;
    logic [wg_w-1:0]         wg_q, wg_d;
    logic [lce_w-1:0]        lce_q, lce_d;
    logic [way_w-1:0]        way_q, way_d;
    logic [tag_width_p-1:0]  tag_q, tag_d;
    logic [coh_bits_p-1:0]   coh_q, coh_d;
    logic                    so_q, so_d;
    logic [row_width_lp-1:0] row_q, row_d;

    logic [addr_w-1:0]       row_addr;
    logic [31:0]             off;
    logic [row_width_lp-1:0] mask, merged;
    logic [entry_w-1:0]      old_entry, new_entry;

    // Division/modulo by tag_sets_per_row_p splits lce into row select and tag set; a single-row
    // way-group therefore collapses to address = wg.
    assign row_addr  = addr_w'(int'(wg_q) * rows_per_wg_p + int'(lce_q) / tag_sets_per_row_p);
    assign off       = 32'(((int'(lce_q) % tag_sets_per_row_p) * lce_assoc_p + int'(way_q)) * entry_w);
    assign mask      = {{(row_width_lp-entry_w){1'b0}}, {entry_w{1'b1}}} << off;
    assign old_entry = entry_w'(ram_data_i >> off);
    assign new_entry = {so_q ? old_entry[entry_w-1:coh_bits_p] : tag_q, coh_q};
    assign merged    = (ram_data_i & ~mask) | ({{(row_width_lp-entry_w){1'b0}}, new_entry} << off);

    assign ready_o    = reset_n_i & (state_q == e_ready);
    assign ram_v_o    = (state_q == e_read) | (state_q == e_write);
    assign ram_w_o    = state_q == e_write;
    assign done_o     = ram_w_o;
    assign ram_addr_o = ram_v_o ? row_addr : '0;
    assign ram_data_o = ram_w_o ? row_q : '0;

    // State and latched request registers; reset abandons any update in flight
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= e_ready;
            wg_q    <= '0;
            lce_q   <= '0;
            way_q   <= '0;
            tag_q   <= '0;
            coh_q   <= '0;
            so_q    <= 1'b0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            wg_q    <= wg_d;
            lce_q   <= lce_d;
            way_q   <= way_d;
            tag_q   <= tag_d;
            coh_q   <= coh_d;
            so_q    <= so_d;
            row_q   <= row_d;
        end
    end

    // Sequencing: accept -> read row -> merge returned row -> write back
    always_comb begin
        state_d = state_q;
        wg_d    = wg_q;
        lce_d   = lce_q;
        way_d   = way_q;
        tag_d   = tag_q;
        coh_d   = coh_q;
        so_d    = so_q;
        row_d   = row_q;
        case (state_q)
            e_ready: if (v_i) begin
                state_d = e_read;
                wg_d    = wg_i;
                lce_d   = lce_i;
                way_d   = way_i;
                tag_d   = tag_i;
                coh_d   = state_i;
                so_d    = state_only_i;
            end
            e_read:  state_d = e_merge;
            e_merge: begin
                row_d   = merged;
                state_d = e_write;
            end
            default: state_d = e_ready;
        endcase
    end
endmodule

// File: tb/tb_bp_cce_dir_entry_writer.sv
// tb_bp_cce_dir_entry_writer: scoreboard bench with a RAM model for the directory entry writer
module tb_bp_cce_dir_entry_writer;
    logic         clk = 1'b0;
    logic         reset_n_i = 1'b0;
    logic         v_i = 1'b0;
    logic         ready_o;
    logic [5:0]   wg_i = '0;
    logic [1:0]   lce_i = '0;
    logic [2:0]   way_i = '0;
    logic [9:0]   tag_i = '0;
    logic [2:0]   state_i = '0;
    logic         state_only_i = 1'b0;
    logic         ram_v_o, ram_w_o, done_o;
    logic [6:0]   ram_addr_o;
    logic [207:0] ram_data_o;
    logic [207:0] ram_data_i = '0;

    always #5 clk = ~clk;

    bp_cce_dir_entry_writer dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o),
        .wg_i(wg_i), .lce_i(lce_i), .way_i(way_i), .tag_i(tag_i), .state_i(state_i),
        .state_only_i(state_only_i), .ram_v_o(ram_v_o), .ram_w_o(ram_w_o),
        .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i),
        .done_o(done_o)
    );

    typedef struct {
        logic [6:0]   a;
        logic [207:0] d;
        int           c;
    } exp_t;
    exp_t q[$];

    int n_chk = 0, n_fail = 0, cyc = 0, n_wr = 0;

    logic [207:0] mem [128];
    logic         clr = 1'b1, pl_en = 1'b0;
    logic [6:0]   pl_a = '0;
    logic [207:0] pl_d = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: read data returns one cycle after the read
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 128; i++) mem[i] <= '0;
        end else if (pl_en) mem[pl_a] <= pl_d;
        else if (ram_v_o && ram_w_o) mem[ram_addr_o] <= ram_data_o;
        if (ram_v_o && !ram_w_o) ram_data_i <= mem[ram_addr_o];
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every RAM write
    always @(negedge clk) begin
        if (ram_v_o && !ram_w_o && q.size() > 0) begin
            chk("rd_addr", 256'(ram_addr_o), 256'(q[0].a));
            chk("rd_cycle", 256'(cyc), 256'(q[0].c - 2));
        end
        if (ram_v_o && ram_w_o) begin
            n_wr++;
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: addr %h data %h with no request pending", ram_addr_o, ram_data_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wr_addr", 256'(ram_addr_o), 256'(e.a));
                chk("wr_data", 256'(ram_data_o), 256'(e.d));
                chk("wr_cycle", 256'(cyc), 256'(e.c));
                chk("wr_done", 256'(done_o), 256'(1));
            end
        end else if (done_o) chk("done_without_write", 256'(ram_w_o), 256'(1));
    end

    task automatic preload(input logic [6:0] a, input logic [207:0] d);
        pl_a = a;
        pl_d = d;
        pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic req(input logic [5:0] wg, input logic [1:0] lce, input logic [2:0] way,
                       input logic [9:0] tag, input logic [2:0] st, input logic so,
                       input logic push, input logic [6:0] a, input logic [207:0] d);
        int t = 0;
        while (!ready_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("req_ready", 256'(ready_o), 256'(1));
        wg_i = wg; lce_i = lce; way_i = way; tag_i = tag; state_i = st; state_only_i = so;
        v_i = 1'b1;
        if (push) q.push_back('{a: a, d: d, c: cyc + 3});
        @(negedge clk);
        v_i = 1'b0;
        wg_i = ~wg; lce_i = ~lce; way_i = ~way; tag_i = ~tag; state_i = ~st; state_only_i = ~so;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || !ready_o) && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", 256'(q.size()), 256'(0));
    endtask

    initial begin
        logic [207:0] e, p;
        int wr0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", 256'(ready_o), 256'(0));
            chk("rst_ram_v", 256'(ram_v_o), 256'(0));
            chk("rst_done", 256'(done_o), 256'(0));
        end
        reset_n_i = 1'b1;
        clr = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 256'(ready_o), 256'(1));

        preload(7'd11, '1);
        e = '1;
        e[142:130] = {10'h2A5, 3'b011};
        req(6'd5, 2'd3, 3'd2, 10'h2A5, 3'b011, 1'b0, 1'b1, 7'd11, e);
        drain();

        p = {13{16'hC3A5}};
        p[12:0] = {10'h155, 3'b001};
        preload(7'd4, p);
        e = p;
        e[12:0] = {10'h155, 3'b100};
        req(6'd2, 2'd0, 3'd0, 10'h3FF, 3'b100, 1'b1, 1'b1, 7'd4, e);
        drain();

        e = '0;
        e[207:195] = {10'h3C3, 3'b110};
        req(6'd63, 2'd3, 3'd7, 10'h3C3, 3'b110, 1'b0, 1'b1, 7'd127, e);
        drain();

        for (int k = 0; k < 10; k++) begin
            wg_i = 6'(k + 10);
            lce_i = 2'((k >> 2) + 1);
            way_i = 3'(7 - (k % 8));
            tag_i = 10'(10'h100 + k);
            state_i = 3'(k);
            state_only_i = 1'b0;
            v_i = 1'b1;
            chk("busy_ready", 256'(ready_o), 256'(k % 4 == 0));
            e = '0;
            if (k == 0) begin
                e[207:195] = {10'h100, 3'd0};
                q.push_back('{a: 7'd20, d: e, c: cyc + 3});
            end else if (k == 4) begin
                e[51:39] = {10'h104, 3'd4};
                q.push_back('{a: 7'd29, d: e, c: cyc + 3});
            end else if (k == 8) begin
                e[207:195] = {10'h108, 3'd0};
                q.push_back('{a: 7'd37, d: e, c: cyc + 3});
            end
            @(negedge clk);
        end
        v_i = 1'b0;
        drain();

        wr0 = n_wr;
        req(6'd1, 2'd2, 3'd5, 10'h2AA, 3'b010, 1'b0, 1'b0, 7'd0, '0);
        reset_n_i = 1'b0;
        @(negedge clk);
        chk("abort_rst_ready", 256'(ready_o), 256'(0));
        chk("abort_rst_ram_v", 256'(ram_v_o), 256'(0));
        reset_n_i = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_write", 256'(n_wr), 256'(wr0));
        e = '0;
        e[77:65] = 13'h1FFF;
        req(6'd1, 2'd2, 3'd5, 10'h3FF, 3'b111, 1'b0, 1'b1, 7'd3, e);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
